// File: rtl/cluster_resp_merge.sv
// cluster_resp_merge: merges the in-order response streams of NrClusters Ara
// clusters into one response toward CVA6. Each cluster feeds a small FIFO.
// Once every FIFO holds the oldest response, a single registered response is
// emitted and all FIFO heads are popped together.
// Optional build macro: CLUSTER_RESP_MERGE_CHECK_EN adds a sticky mismatch_o
// flag. It is set when the cluster results of a merged response disagree.
module cluster_resp_merge #(
  parameter int NrClusters = 4,
  parameter int DataWidth  = 64,
  parameter int CauseWidth = 6,
  parameter int FifoDepth  = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NrClusters-1:0]                 clus_valid_i,
  output logic [NrClusters-1:0]                 clus_ready_o,
  input  logic [NrClusters-1:0][DataWidth-1:0]  clus_result_i,
  input  logic [NrClusters-1:0]                 clus_exc_i,
  input  logic [NrClusters-1:0][CauseWidth-1:0] clus_cause_i,
  output logic                                  resp_valid_o,
  input  logic                                  resp_ready_i,
  output logic [DataWidth-1:0]                  resp_result_o,
  output logic                                  resp_exc_o,
  output logic [CauseWidth-1:0]                 resp_cause_o,
  output logic [$clog2(NrClusters)-1:0]         resp_src_o
`ifdef CLUSTER_RESP_MERGE_CHECK_EN
  ,
  output logic                                  mismatch_o
`endif
);

  localparam int AddrW = $clog2(FifoDepth);
  localparam int PtrW  = AddrW + 1;
  localparam int SrcW  = $clog2(NrClusters);

  // Pointers carry one extra wrap bit so that full and empty can be told apart.
  logic [NrClusters-1:0][PtrW-1:0] wr_ptr, rd_ptr;

  logic [DataWidth-1:0]  mem_result [NrClusters][FifoDepth];
  logic                  mem_exc    [NrClusters][FifoDepth];
  logic [CauseWidth-1:0] mem_cause  [NrClusters][FifoDepth];

  logic [NrClusters-1:0]                 full, empty, push;
  logic [NrClusters-1:0][DataWidth-1:0]  head_result;
  logic [NrClusters-1:0]                 head_exc;
  logic [NrClusters-1:0][CauseWidth-1:0] head_cause;
  logic                                  heads_ok, load;

  logic                  nxt_exc;
  logic [CauseWidth-1:0] nxt_cause;
  logic [SrcW-1:0]       nxt_src;
  logic                  found;

  // FIFO status, push qualification and head read for every cluster
  always_comb begin
    for (int c = 0; c < NrClusters; c++) begin
      full[c]        = (wr_ptr[c][PtrW-1] != rd_ptr[c][PtrW-1]) &&
                       (wr_ptr[c][AddrW-1:0] == rd_ptr[c][AddrW-1:0]);
      empty[c]       = (wr_ptr[c] == rd_ptr[c]);
      push[c]        = clus_valid_i[c] && !full[c];
      head_result[c] = mem_result[c][rd_ptr[c][AddrW-1:0]];
      head_exc[c]    = mem_exc[c][rd_ptr[c][AddrW-1:0]];
      head_cause[c]  = mem_cause[c][rd_ptr[c][AddrW-1:0]];
    end
  end

  // Ready depends only on occupancy, so a full FIFO refuses a push even in a popping cycle.
  assign clus_ready_o = ~full;
  assign heads_ok     = ~|empty;
  assign load         = heads_ok && (!resp_valid_o || resp_ready_i);

  // Pointer update: push on handshake, pop all FIFOs together on load
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      for (int c = 0; c < NrClusters; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + PtrW'(1);
        if (load)    rd_ptr[c] <= rd_ptr[c] + PtrW'(1);
      end
    end
  end

  // FIFO storage write
  // NOTE: storage has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NrClusters; c++) begin
      if (push[c]) begin
        mem_result[c][wr_ptr[c][AddrW-1:0]] <= clus_result_i[c];
        mem_exc[c][wr_ptr[c][AddrW-1:0]]    <= clus_exc_i[c];
        mem_cause[c][wr_ptr[c][AddrW-1:0]]  <= clus_cause_i[c];
      end
    end
  end

  // Exception merge: OR of flags, cause and source from the lowest excepting cluster
  always_comb begin
    // NOTE: every variable gets a default first, so no latch can be inferred.
    found     = 1'b0;
    nxt_exc   = 1'b0;
    nxt_cause = '0;
    nxt_src   = '0;
    for (int c = 0; c < NrClusters; c++) begin
      if (head_exc[c] && !found) begin
        found     = 1'b1;
        nxt_exc   = 1'b1;
        nxt_cause = head_cause[c];
        nxt_src   = SrcW'(c);
      end
    end
  end

  // Output register: load merged heads, otherwise drop valid once accepted
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_valid_o  <= 1'b0;
      resp_result_o <= '0;
      resp_exc_o    <= 1'b0;
      resp_cause_o  <= '0;
      resp_src_o    <= '0;
    end else if (load) begin
      resp_valid_o  <= 1'b1;
      resp_result_o <= head_result[0];
      resp_exc_o    <= nxt_exc;
      resp_cause_o  <= nxt_cause;
      resp_src_o    <= nxt_src;
    end else if (resp_ready_i) begin
      resp_valid_o  <= 1'b0;
    end
  end

`ifdef CLUSTER_RESP_MERGE_CHECK_EN
  logic            mis_any;
  logic [SrcW-1:0] mis_idx;

  // Find the first cluster whose head result disagrees with cluster 0
  always_comb begin
    mis_any = 1'b0;
    mis_idx = '0;
    for (int c = 1; c < NrClusters; c++) begin
      if (head_result[c] != head_result[0] && !mis_any) begin
        mis_any = 1'b1;
        mis_idx = SrcW'(c);
      end
    end
  end

  // Sticky mismatch flag, sampled only when a response is merged
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)               mismatch_o <= 1'b0;
    else if (load && mis_any) mismatch_o <= 1'b1;
  end

`ifndef SYNTHESIS
  // Simulation report naming the disagreeing cluster
  always_ff @(posedge clk_i) begin
    if (!rst_i && load && mis_any)
      $error("cluster_resp_merge: result mismatch from cluster %0d", mis_idx);
  end
`endif
`endif

endmodule

// File: tb/tb_cluster_resp_merge.sv
// Self-checking bench for cluster_resp_merge (NrClusters=4, FifoDepth=4).
// A queue-based reference model tracks per-cluster buffered responses and the
// registered output; directed scenarios are followed by a randomized phase.
module tb_cluster_resp_merge;
  localparam int NC = 4;
  localparam int DW = 64;
  localparam int CW = 6;
  localparam int FD = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NC-1:0]         clus_valid, clus_ready, clus_exc;
  logic [NC-1:0][DW-1:0] clus_result;
  logic [NC-1:0][CW-1:0] clus_cause;
  logic                  resp_valid, resp_ready, resp_exc;
  logic [DW-1:0]         resp_result;
  logic [CW-1:0]         resp_cause;
  logic [1:0]            resp_src;
`ifdef CLUSTER_RESP_MERGE_CHECK_EN
  logic                  mismatch;
`endif

  always #5 clk = ~clk;

  cluster_resp_merge #(.NrClusters(NC), .DataWidth(DW), .CauseWidth(CW), .FifoDepth(FD)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clus_valid_i  (clus_valid),
    .clus_ready_o  (clus_ready),
    .clus_result_i (clus_result),
    .clus_exc_i    (clus_exc),
    .clus_cause_i  (clus_cause),
    .resp_valid_o  (resp_valid),
    .resp_ready_i  (resp_ready),
    .resp_result_o (resp_result),
    .resp_exc_o    (resp_exc),
    .resp_cause_o  (resp_cause),
    .resp_src_o    (resp_src)
`ifdef CLUSTER_RESP_MERGE_CHECK_EN
    ,
    .mismatch_o    (mismatch)
`endif
  );

  typedef struct {
    logic [DW-1:0] res;
    logic          exc;
    logic [CW-1:0] cause;
  } ent_t;

  // Reference model: what each cluster has buffered, and the output register.
  ent_t       mq [NC][$];
  logic       m_valid = 1'b0;
  ent_t       m_out;
  logic [1:0] m_src;

  int            total = 0;
  int            passed = 0;
  int            cyc = 0;
  logic [NC-1:0] acc;
  logic [DW-1:0] got[$];
  int            got_cyc[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int c = 0; c < NC; c++) mq[c].delete();
    m_valid = 1'b0;
  endtask

  task automatic model_check();
    logic [NC-1:0] exp_rdy;
    for (int c = 0; c < NC; c++) exp_rdy[c] = (mq[c].size() < FD);
    check("ready", clus_ready, exp_rdy);
    check("valid", resp_valid, m_valid);
    if (m_valid) begin
      check("result", resp_result, m_out.res);
      check("exc",    resp_exc,    m_out.exc);
      check("cause",  resp_cause,  m_out.cause);
      check("src",    resp_src,    m_src);
    end
  endtask

  // Advance the model across one clock edge using the current inputs.
  task automatic model_update();
    logic          do_load;
    logic [NC-1:0] pz;
    ent_t          e;
    do_load = 1'b1;
    for (int c = 0; c < NC; c++) if (mq[c].size() == 0) do_load = 1'b0;
    do_load = do_load && (!m_valid || resp_ready);
    for (int c = 0; c < NC; c++) pz[c] = clus_valid[c] && (mq[c].size() < FD);
    if (do_load) begin
      m_out.res   = mq[0][0].res;
      m_out.exc   = 1'b0;
      m_out.cause = '0;
      m_src       = '0;
      for (int c = NC - 1; c >= 0; c--) begin
        if (mq[c][0].exc) begin
          m_out.exc   = 1'b1;
          m_out.cause = mq[c][0].cause;
          m_src       = 2'(c);
        end
      end
      m_valid = 1'b1;
      for (int c = 0; c < NC; c++) void'(mq[c].pop_front());
    end else if (resp_ready) begin
      m_valid = 1'b0;
    end
    for (int c = 0; c < NC; c++) begin
      if (pz[c]) begin
        e.res   = clus_result[c];
        e.exc   = clus_exc[c];
        e.cause = clus_cause[c];
        mq[c].push_back(e);
      end
    end
  endtask

  // One clock cycle: compare, record handshakes, advance model, cross the edge.
  task automatic tick();
    #2;
    model_check();
    acc = clus_valid & clus_ready;
    if (resp_valid && resp_ready) begin
      got.push_back(resp_result);
      got_cyc.push_back(cyc);
    end
    model_update();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic push_all(input logic [DW-1:0] v);
    clus_valid = '1;
    for (int c = 0; c < NC; c++) clus_result[c] = v;
    clus_exc   = '0;
    clus_cause = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            when_c [NC];
    int            idx [NC];
    int            kk [NC];
    int            acc0;
    int            min_k;
    logic [DW-1:0] seqv [512];
    logic          pend_exc [NC];
    logic [CW-1:0] pend_cause [NC];

    rst         = 1'b1;
    clus_valid  = '0;
    clus_result = '0;
    clus_exc    = '0;
    clus_cause  = '0;
    resp_ready  = 1'b1;

    // Reset state, checked before any clock edge.
    #2;
    check("rst_valid",  resp_valid,  0);
    check("rst_result", resp_result, 0);
    check("rst_exc",    resp_exc,    0);
    check("rst_cause",  resp_cause,  0);
    check("rst_src",    resp_src,    0);
    check("rst_ready",  clus_ready,  4'hF);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();

    // Single request: all clusters push 0xA5 in cycle t.
    push_all(64'hA5);
    tick();
    clus_valid = '0;
    check("single_t1_valid", resp_valid, 0);
    tick();
    check("single_t2_valid",  resp_valid,  1);
    check("single_t2_result", resp_result, 64'hA5);
    check("single_t2_exc",    resp_exc,    0);
    check("single_t2_src",    resp_src,    0);
    check("single_ready",     clus_ready,  4'hF);
    repeat (3) tick();

    // Staggered arrival at cycles 0, 3, 5, 9: valid first high at cycle 11.
    when_c = '{0, 3, 5, 9};
    got.delete();
    got_cyc.delete();
    for (int k = 0; k < 14; k++) begin
      for (int c = 0; c < NC; c++) begin
        clus_valid[c]  = (k == when_c[c]);
        clus_result[c] = 64'h5A;
      end
      check("stagger_valid", resp_valid, (k == 11));
      tick();
    end
    clus_valid = '0;
    check("stagger_count", got.size(), 1);

    // Exception priority: flags 4'b1010, cluster 1 cause 0x0D wins over 0x02.
    push_all(64'h77);
    clus_exc   = 4'b1010;
    clus_cause = {6'h02, 6'h2A, 6'h0D, 6'h15};
    tick();
    clus_valid = '0;
    tick();
    check("exc_flag",  resp_exc,   1);
    check("exc_cause", resp_cause, 6'h0D);
    check("exc_src",   resp_src,   1);
    repeat (2) tick();

    // Backpressure: ready low, every cluster streams 1..6.
    resp_ready = 1'b0;
    clus_exc   = '0;
    clus_cause = '0;
    idx  = '{0, 0, 0, 0};
    acc0 = 0;
    got.delete();
    got_cyc.delete();
    repeat (10) begin
      for (int c = 0; c < NC; c++) begin
        clus_valid[c]  = (idx[c] < 6);
        clus_result[c] = 64'(idx[c] + 1);
      end
      tick();
      for (int c = 0; c < NC; c++) if (acc[c]) idx[c]++;
      if (acc[0]) acc0++;
    end
    check("bp_accepted", acc0, 5);
    check("bp_ready0",   clus_ready[0], 0);
    check("bp_hold",     resp_result,   1);
    resp_ready = 1'b1;
    repeat (10) begin
      for (int c = 0; c < NC; c++) begin
        clus_valid[c]  = (idx[c] < 6);
        clus_result[c] = 64'(idx[c] + 1);
      end
      tick();
      for (int c = 0; c < NC; c++) if (acc[c]) idx[c]++;
    end
    clus_valid = '0;
    check("bp_count", got.size(), 6);
    for (int i = 0; i < got.size(); i++) begin
      check("bp_order", got[i], 64'(i + 1));
      if (i > 0) check("bp_consecutive", got_cyc[i] - got_cyc[i-1], 1);
    end

    // Async reset with a held response and three buffered entries.
    resp_ready = 1'b0;
    for (int v = 0; v < 4; v++) begin
      push_all(64'(8'h21 + v));
      tick();
    end
    clus_valid = '0;
    tick();
    check("pre_rst_valid", resp_valid, 1);
    check("pre_rst_ready", clus_ready, 4'hF);
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid",  resp_valid,  0);
    check("arst_result", resp_result, 0);
    check("arst_exc",    resp_exc,    0);
    check("arst_cause",  resp_cause,  0);
    check("arst_src",    resp_src,    0);
    check("arst_ready",  clus_ready,  4'hF);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    resp_ready = 1'b1;
    got.delete();
    got_cyc.delete();
    repeat (6) tick();
    check("no_stale", got.size(), 0);

    // Randomized traffic: clusters share one result sequence, exceptions are per cluster.
    for (int j = 0; j < 512; j++) seqv[j] = {$urandom, $urandom};
    for (int c = 0; c < NC; c++) begin
      kk[c]         = 0;
      pend_exc[c]   = ($urandom_range(0, 3) == 0);
      pend_cause[c] = 6'($urandom);
    end
    got.delete();
    got_cyc.delete();
    for (int i = 0; i < 400; i++) begin
      resp_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NC; c++) begin
        clus_valid[c]  = ($urandom_range(0, 9) < 7) && (kk[c] < 512);
        clus_result[c] = seqv[kk[c]];
        clus_exc[c]    = pend_exc[c];
        clus_cause[c]  = pend_cause[c];
      end
      tick();
      for (int c = 0; c < NC; c++) begin
        if (acc[c]) begin
          kk[c]++;
          pend_exc[c]   = ($urandom_range(0, 3) == 0);
          pend_cause[c] = 6'($urandom);
        end
      end
    end
    clus_valid = '0;
    resp_ready = 1'b1;
    repeat (10) tick();
    min_k = kk[0];
    for (int c = 1; c < NC; c++) if (kk[c] < min_k) min_k = kk[c];
    check("rand_count", got.size(), min_k);
    for (int j = 0; j < got.size(); j++) check("rand_order", got[j], seqv[j]);

`ifdef CLUSTER_RESP_MERGE_CHECK_EN
    // Result mismatch: cluster 2 disagrees, flag is sticky until reset.
    rst = 1'b1;
    #1;
    model_clear();
    check("mis_rst", mismatch, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_all(64'h10);
    clus_result[2] = 64'h11;
    tick();
    clus_valid = '0;
    tick();
    check("mis_result", resp_result, 64'h10);
    check("mis_flag",   mismatch,    1);
    tick();
    push_all(64'h10);
    tick();
    clus_valid = '0;
    tick();
    check("mis_next_valid", resp_valid, 1);
    check("mis_sticky",     mismatch,   1);
    repeat (2) tick();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
